// File: rtl/rc_seq_pkg.sv
// Shared types and constants for the RemoteComm command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_SNT  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_CHECK     = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  // Response the robot returns when a calibration/move completes.
  localparam logic [7:0] RESP_CAL_DONE = 8'hA5;

endpackage

// File: rtl/rc_step_timer.sv
// Per-step watchdog: loadable down-counter that saturates at zero.
// Latency: expired is a pure decode of the registered count (same cycle).
// Backpressure: none; load has priority over en.
module rc_step_timer #(
  parameter int unsigned TIMEOUT = 1_000_000,
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q;

  // Reload to TIMEOUT-1 while idle; count down towards zero while a step is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rc_cmd_sequencer.sv
// Scripted command sequencer: issues stored commands to RemoteComm and checks responses.
// Latency: start -> snd_cmd next cycle; resp_rdy -> next snd_cmd or done two cycles later.
// Backpressure: waits on cmd_snt/resp_rdy per step; a step fails after TIMEOUT cycles.
module rc_cmd_sequencer
  import rc_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CMD_W   = 16,
  parameter int unsigned RESP_W  = 8,
  parameter int unsigned TIMEOUT = 1_000_000,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [CMD_W-1:0]  ld_cmd,
  input  logic [RESP_W-1:0] ld_exp,
  input  logic              ld_chk,
  input  logic [AW:0]       num_steps,
  input  logic              start,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW-1:0]     fail_step,
  output logic [1:0]        fail_code,
  output logic [AW-1:0]     step_idx
);

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [RESP_W-1:0] exp;
    logic              chk;
  } entry_t;

  entry_t            script_q [DEPTH];
  state_e            state_q;
  logic [CMD_W-1:0]  cmd_q;
  logic              snd_cmd_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [AW-1:0]     fail_step_q;
  logic [1:0]        fail_code_q;
  logic [AW-1:0]     step_idx_q;
  logic [AW:0]       nsteps_q;
  logic [RESP_W-1:0] resp_q;
  logic              sticky_q;

  logic              launch;
  logic [AW:0]       nsteps_d;
  logic [AW-1:0]     step_nxt;
  logic              last_step;
  logic              mismatch;
  logic              tmr_load;
  logic              tmr_expired;

  // Decode launch, saturated length, step bookkeeping and response check.
  always_comb begin
    launch    = start && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
    nsteps_d  = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
    step_nxt  = step_idx_q + AW'(1);
    last_step = ({1'b0, step_idx_q} == (nsteps_q - (AW+1)'(1)));
    mismatch  = script_q[step_idx_q].chk && (resp_q != script_q[step_idx_q].exp);
    // Timer sits reloaded outside a step, so it already holds TIMEOUT-1 in the snd_cmd cycle.
    tmr_load  = (state_q == ST_IDLE) || (state_q == ST_CHECK) || (state_q == ST_FINISH);
  end

  rc_step_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (!tmr_load),
    .expired (tmr_expired)
  );

  // Script storage: host writes are only accepted between runs; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && !busy_q) begin
      script_q[ld_addr] <= '{cmd: ld_cmd, exp: ld_exp, chk: ld_chk};
    end
  end

  // Sequencing FSM: issue, wait for send and response, check, finish on first failure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      snd_cmd_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= '0;
      fail_code_q <= FC_NONE;
      step_idx_q  <= '0;
      nsteps_q    <= '0;
      resp_q      <= '0;
      sticky_q    <= 1'b0;
    end else begin
      snd_cmd_q <= 1'b0;
      if (launch) begin
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        fail_code_q <= FC_NONE;
        fail_step_q <= '0;
        step_idx_q  <= '0;
        sticky_q    <= 1'b0;
        nsteps_q    <= nsteps_d;
        if (num_steps == '0) begin
          // Empty script: FINISH reports pass one cycle later.
          state_q <= ST_FINISH;
        end else begin
          busy_q    <= 1'b1;
          cmd_q     <= script_q[0].cmd;
          snd_cmd_q <= 1'b1;
          state_q   <= ST_ISSUE;
        end
      end else begin
        case (state_q)
          ST_ISSUE: begin
            if (resp_rdy) begin
              sticky_q <= 1'b1;
              resp_q   <= resp;
            end
            state_q <= ST_WAIT_SNT;
          end
          ST_WAIT_SNT: begin
            // An early response is parked until cmd_snt arrives.
            if (resp_rdy) begin
              sticky_q <= 1'b1;
              resp_q   <= resp;
            end
            if (cmd_snt || (tmr_expired && resp_rdy)) begin
              state_q <= ST_WAIT_RESP;
            end else if (tmr_expired) begin
              state_q     <= ST_FINISH;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              pass_q      <= 1'b0;
              fail_code_q <= FC_TIMEOUT;
              fail_step_q <= step_idx_q;
            end
          end
          ST_WAIT_RESP: begin
            // A response in the expiry cycle still counts.
            if (resp_rdy || sticky_q) begin
              if (resp_rdy) begin
                resp_q <= resp;
              end
              sticky_q <= 1'b0;
              state_q  <= ST_CHECK;
            end else if (tmr_expired) begin
              state_q     <= ST_FINISH;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              pass_q      <= 1'b0;
              fail_code_q <= FC_TIMEOUT;
              fail_step_q <= step_idx_q;
            end
          end
          ST_CHECK: begin
            if (mismatch) begin
              state_q     <= ST_FINISH;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              pass_q      <= 1'b0;
              fail_code_q <= FC_MISMATCH;
              fail_step_q <= step_idx_q;
            end else if (last_step) begin
              state_q <= ST_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              step_idx_q <= step_nxt;
              cmd_q      <= script_q[step_nxt].cmd;
              snd_cmd_q  <= 1'b1;
              state_q    <= ST_ISSUE;
            end
          end
          ST_FINISH: begin
            done_q  <= 1'b1;
            pass_q  <= (fail_code_q == FC_NONE);
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd       = cmd_q;
  assign snd_cmd   = snd_cmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;
  assign fail_code = fail_code_q;
  assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_rc_cmd_sequencer.sv
// Bench for rc_cmd_sequencer: table of scripts plus hand-built corner sequences.
// A RemoteComm responder model replies with configurable delays; a scoreboard checks commands and results.
module tb_rc_cmd_sequencer;
  import rc_seq_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 100;
  localparam int AW      = 4;

  logic          clk;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_cmd;
  logic [7:0]    ld_exp;
  logic          ld_chk;
  logic [AW:0]   num_steps;
  logic          start;
  logic [15:0]   cmd;
  logic          snd_cmd;
  logic          cmd_snt;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_step;
  logic [1:0]    fail_code;
  logic [AW-1:0] step_idx;

  rc_cmd_sequencer #(.DEPTH(DEPTH), .CMD_W(16), .RESP_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_cmd(ld_cmd),
    .ld_exp(ld_exp), .ld_chk(ld_chk), .num_steps(num_steps), .start(start),
    .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .pass(pass), .fail_step(fail_step),
    .fail_code(fail_code), .step_idx(step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pass;
    logic [1:0] code;
    logic [3:0] step;
  } res_t;

  typedef struct {
    int               n_load;
    int               nsteps;
    int               snt;
    int               rsp;
    logic [15:0][15:0] cmd;
    logic [15:0][7:0]  exp;
    logic [15:0]       chk;
    logic [15:0][7:0]  rsp_v;
    logic             e_pass;
    logic [1:0]       e_code;
    logic [3:0]       e_step;
    int               e_snd;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] exp_cmd_q[$];
  res_t        exp_res_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Responder configuration, written by the main sequence.
  int        snt_dly = 1;
  int        rsp_dly = 2;
  bit        rsp_en = 1'b1;
  bit        strict = 1'b0;
  logic [7:0] rsp_val[16];
  int        snd_cnt = 0;
  int        snd_in_run = 0;
  int        last_rsp = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [3:0] a, input logic [15:0] c, input logic [7:0] e, input logic k);
    ld_en = 1'b1; ld_addr = a; ld_cmd = c; ld_exp = e; ld_chk = k;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (!done && k < lim) begin
      tick();
      k++;
    end
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  function automatic vec_t mk(input int nl, input int ns, input int sd, input int rd,
                              input logic p, input logic [1:0] c, input logic [3:0] s, input int nsnd);
    vec_t v;
    for (int i = 0; i < 16; i++) begin
      v.cmd[i]   = 16'h1000 + 16'(i);
      v.exp[i]   = RESP_CAL_DONE;
      v.chk[i]   = 1'b1;
      v.rsp_v[i] = RESP_CAL_DONE;
    end
    v.n_load = nl; v.nsteps = ns; v.snt = sd; v.rsp = rd;
    v.e_pass = p; v.e_code = c; v.e_step = s; v.e_snd = nsnd;
    return v;
  endfunction

  // RemoteComm model plus scoreboard monitor for commands and final results.
  initial begin
    logic [15:0] e;
    res_t        r;
    bit          pend;
    int          pc;
    int          cur;
    logic        done_prev;
    pend = 1'b0; pc = 0; cur = 0; done_prev = 1'b0;
    cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
    forever begin
      tick();
      cyc++;
      cmd_snt = 1'b0;
      resp_rdy = 1'b0;
      if (!busy) pend = 1'b0;
      if (snd_cmd === 1'b1) begin
        if (exp_cmd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_snd_cmd: got cmd 0x%0h, expected no command (cycle %0d)", cmd, cyc);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_value", 32'(cmd), 32'(e));
        end
        if (strict && snd_in_run > 0) chk("snd_gap_after_resp", 32'(cyc), 32'(last_rsp + 2));
        cur = snd_in_run;
        snd_in_run++;
        snd_cnt++;
        pend = 1'b1;
        pc = 0;
      end else if (pend) begin
        pc++;
        if (pc == snt_dly) cmd_snt = 1'b1;
        if (rsp_en && pc == rsp_dly) begin
          resp_rdy = 1'b1;
          resp = rsp_val[cur];
          last_rsp = cyc;
        end
        if (pc >= snt_dly && (!rsp_en || pc >= rsp_dly)) pend = 1'b0;
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_res_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
        end else begin
          r = exp_res_q.pop_front();
          chk("res_pass", 32'(pass), 32'(r.pass));
          chk("res_fail_code", 32'(fail_code), 32'(r.code));
          chk("res_fail_step", 32'(fail_step), 32'(r.step));
          chk("res_busy_clear", 32'(busy), 32'd0);
          if (strict) chk("done_after_resp", 32'(cyc), 32'(last_rsp + 2));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int first;
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_cmd = '0; ld_exp = '0; ld_chk = 1'b0;
    num_steps = '0; start = 1'b0;
    for (int i = 0; i < 16; i++) rsp_val[i] = '0;

    vecs[0] = mk(2, 2, 1, 2, 1'b1, FC_NONE, 4'd0, 2);
    vecs[0].cmd[0] = 16'h0000; vecs[0].cmd[1] = 16'h4022;
    vecs[1] = vecs[0];
    vecs[1].rsp_v[1] = 8'h5A; vecs[1].e_pass = 1'b0; vecs[1].e_code = FC_MISMATCH; vecs[1].e_step = 4'd1;
    vecs[2] = mk(3, 3, 1, 2, 1'b1, FC_NONE, 4'd0, 3);
    vecs[2].chk[1] = 1'b0; vecs[2].rsp_v[1] = 8'h00;
    vecs[3] = mk(3, 3, 2, 4, 1'b0, FC_MISMATCH, 4'd0, 1);
    vecs[3].exp[0] = 8'h3C;
    vecs[4] = mk(16, 20, 1, 3, 1'b1, FC_NONE, 4'd0, 16);
    vecs[5] = mk(2, 2, 3, 1, 1'b1, FC_NONE, 4'd0, 2);
    vecs[6] = mk(2, 2, 3, 1, 1'b0, FC_MISMATCH, 4'd0, 1);
    vecs[6].rsp_v[0] = 8'h77;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_snd_cmd", 32'(snd_cmd), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_step", 32'(fail_step), 32'd0);
    chk("rst_fail_code", 32'(fail_code), 32'(FC_NONE));
    chk("rst_step_idx", 32'(step_idx), 32'd0);
    tick();

    // Table-driven scripts.
    for (int vi = 0; vi < 7; vi++) begin
      for (int i = 0; i < vecs[vi].n_load; i++)
        load_entry(4'(i), vecs[vi].cmd[i], vecs[vi].exp[i], vecs[vi].chk[i]);
      for (int i = 0; i < 16; i++) rsp_val[i] = vecs[vi].rsp_v[i];
      snt_dly = vecs[vi].snt; rsp_dly = vecs[vi].rsp; rsp_en = 1'b1;
      strict = (vecs[vi].rsp > vecs[vi].snt);
      for (int i = 0; i < vecs[vi].e_snd; i++) exp_cmd_q.push_back(vecs[vi].cmd[i]);
      exp_res_q.push_back('{vecs[vi].e_pass, vecs[vi].e_code, vecs[vi].e_step});
      base = snd_cnt; snd_in_run = 0;
      num_steps = 5'(vecs[vi].nsteps);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("snd_after_start", 32'(snd_cmd), 32'd1);
      tick();
      chk("snd_single_pulse", 32'(snd_cmd), 32'd0);
      wait_done(3000);
      repeat (6) tick();
      chk("snd_count", 32'(snd_cnt - base), 32'(vecs[vi].e_snd));
    end

    // Timeout: no response ever; failure visible exactly TIMEOUT cycles after snd_cmd.
    load_entry(4'd0, 16'hBEEF, RESP_CAL_DONE, 1'b1);
    rsp_en = 1'b0; snt_dly = 1; strict = 1'b0; snd_in_run = 0;
    exp_cmd_q.push_back(16'hBEEF);
    exp_res_q.push_back('{1'b0, FC_TIMEOUT, 4'd0});
    num_steps = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_snd_cycle", 32'(snd_cmd), 32'd1);
    first = -1;
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (done && first < 0) first = k;
    end
    chk("to_latency", 32'(first), 32'(TIMEOUT));
    chk("to_fail_code", 32'(fail_code), 32'(FC_TIMEOUT));
    chk("to_fail_step", 32'(fail_step), 32'd0);

    // Response arriving in the very cycle the counter expires wins.
    load_entry(4'd0, 16'h1234, RESP_CAL_DONE, 1'b1);
    rsp_en = 1'b1; snt_dly = 1; rsp_dly = TIMEOUT - 1; strict = 1'b1; snd_in_run = 0;
    rsp_val[0] = RESP_CAL_DONE;
    exp_cmd_q.push_back(16'h1234);
    exp_res_q.push_back('{1'b1, FC_NONE, 4'd0});
    num_steps = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300);
    chk("tie_pass", 32'(pass), 32'd1);
    repeat (3) tick();

    // Reset while waiting for a response.
    load_entry(4'd0, 16'h2001, RESP_CAL_DONE, 1'b1);
    load_entry(4'd1, 16'h2002, RESP_CAL_DONE, 1'b1);
    rsp_en = 1'b0; snt_dly = 1; strict = 1'b0; snd_in_run = 0;
    exp_cmd_q.push_back(16'h2001);
    num_steps = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_snd_cmd", 32'(snd_cmd), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    chk("mid_rst_fail_code", 32'(fail_code), 32'(FC_NONE));
    chk("mid_rst_step_idx", 32'(step_idx), 32'd0);
    repeat (3) tick();

    // Second start and script write while busy are both ignored.
    load_entry(4'd0, 16'hA001, RESP_CAL_DONE, 1'b1);
    load_entry(4'd1, 16'hA002, RESP_CAL_DONE, 1'b1);
    rsp_en = 1'b1; snt_dly = 1; rsp_dly = 10; strict = 1'b1; snd_in_run = 0;
    rsp_val[0] = RESP_CAL_DONE; rsp_val[1] = RESP_CAL_DONE;
    exp_cmd_q.push_back(16'hA001);
    exp_cmd_q.push_back(16'hA002);
    exp_res_q.push_back('{1'b1, FC_NONE, 4'd0});
    base = snd_cnt;
    num_steps = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    ld_en = 1'b1; ld_addr = 4'd1; ld_cmd = 16'hDEAD; ld_exp = 8'h00; ld_chk = 1'b1;
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    wait_done(300);
    repeat (4) tick();
    chk("busy_snd_count", 32'(snd_cnt - base), 32'd2);

    // Empty script: pass reported two cycles after start.
    strict = 1'b0;
    exp_res_q.push_back('{1'b1, FC_NONE, 4'd0});
    num_steps = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done_t1", 32'(done), 32'd0);
    chk("zero_busy_t1", 32'(busy), 32'd0);
    tick();
    chk("zero_done_t2", 32'(done), 32'd1);
    chk("zero_pass_t2", 32'(pass), 32'd1);
    repeat (4) tick();

    chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("result_queue_drained", 32'(exp_res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rc_cmd_sequencer.md
# rc_cmd_sequencer

Parametrised, synthesizable command sequencer for driving the Knight's Tour robot over `RemoteComm`. It stores a script of up to `DEPTH` commands, each paired with an expected response byte. It issues the commands in order through the `snd_cmd`/`cmd_snt`/`resp_rdy` handshake, checks each response, and enforces a per-step timeout. The block sits between a host or bench controller and `RemoteComm`, and reports a single pass/fail result with the index of the first failing step.

## Interface
- `DEPTH`, 16: maximum script length in steps (at least 2).
- `CMD_W`, 16: command width.
- `RESP_W`, 8: response width.
- `TIMEOUT`, 1_000_000: cycles allowed per step, counted from `snd_cmd` to `resp_rdy`.
- `AW`, `$clog2(DEPTH)`: derived; not overridden.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ld_en`  in  1  write one script entry.
- `ld_addr`  in  AW  entry index.
- `ld_cmd`  in  CMD_W  command to issue.
- `ld_exp`  in  RESP_W  expected response.
- `ld_chk`  in  1  1 = compare the response; 0 = accept any response.
- `num_steps`  in  AW+1  script length, sampled on `start`.
- `start`  in  1  single-cycle pulse that launches the script.
- `cmd`  out  CMD_W  to `RemoteComm.cmd`.
- `snd_cmd`  out  1  to `RemoteComm.snd_cmd`.
- `cmd_snt`  in  1  from `RemoteComm`.
- `resp_rdy`  in  1  from `RemoteComm`.
- `resp`  in  RESP_W  from `RemoteComm`.
- `busy`  out  1  script in progress.
- `done`  out  1  script finished; held until the next accepted `start`.
- `pass`  out  1  valid while `done`.
- `fail_step`  out  AW  index of the failing step; 0 on pass.
- `fail_code`  out  2  00 none, 01 mismatch, 10 timeout.
- `step_idx`  out  AW  current or last step index.

## Operation
- Script storage is a `DEPTH`-entry register array of {cmd, exp, chk}. It is written on `ld_en` only while `!busy`; writes while `busy` are dropped. The array is not cleared by `rst`.
- FSM states: IDLE, ISSUE, WAIT_SNT, WAIT_RESP, CHECK, FINISH.
- IDLE, on `start`:
  - `num_steps` = 0 → FINISH with pass.
  - `num_steps` > `DEPTH` → saturate to `DEPTH`.
  - Otherwise clear `done`, `pass`, `fail_*`, set `step_idx` = 0, and go to ISSUE.
- ISSUE: drive `cmd` = entry[`step_idx`].cmd and pulse `snd_cmd` for exactly one cycle. Load the timeout counter with `TIMEOUT`-1. → WAIT_SNT.
- WAIT_SNT: wait for `cmd_snt`, then → WAIT_RESP. If `resp_rdy` arrives here, capture `resp` into a sticky flag and register; it is consumed on entry to WAIT_RESP.
- WAIT_RESP: on `resp_rdy` (or the sticky flag), register `resp` and → CHECK.
- Timeout in WAIT_SNT or WAIT_RESP: counter reaches 0 → FINISH with `fail_code` = 10.
- CHECK:
  - `chk` set and `resp` ≠ exp → FINISH with `fail_code` = 01.
  - Else last step → FINISH with pass.
  - Else increment `step_idx` and → ISSUE.
- FINISH: set `done` = 1. Set `pass` = (`fail_code` == 00). On failure, `fail_step` = `step_idx`. → IDLE.
- Stop on first failure; no later steps are issued.
- `start` while `busy` is ignored.
- Simultaneous `resp_rdy` and timeout expiry in the same cycle: the response wins.
- `rst` mid-script: returns to IDLE within one cycle and drops `snd_cmd`. `RemoteComm` is not notified.

## Timing
- Reset values: `snd_cmd` 0, `cmd` 0, `busy` 0, `done` 0, `pass` 0, `fail_step` 0, `fail_code` 00, `step_idx` 0.
- `start` at cycle t → `busy` = 1 and ISSUE at t+1; `snd_cmd` high during t+1 only.
- `cmd` is registered, valid from t+1, and held stable until the next ISSUE.
- `resp_rdy` at cycle r → compare at r+1. At r+2, either `snd_cmd` for the next step or `done` = 1.
- Minimum inter-command gap: 2 cycles after `resp_rdy`.
- Timeout: step fails exactly `TIMEOUT` cycles after its `snd_cmd` cycle if no response has arrived.
- `done`, `pass`, `fail_*` update in the same edge that clears `busy`.
- `num_steps` = 0 → `done` = 1 and `pass` = 1 at t+2.

## Structure
- `rc_seq_pkg`: `typedef enum logic [2:0]` state type; `fail_code` constants `FC_NONE`, `FC_MISMATCH`, `FC_TIMEOUT`; `RESP_CAL_DONE` = 8'hA5.
- One natural sub-module, `rc_step_timer`: a loadable down-counter with `load`, `en` and `expired` outputs, `$clog2(TIMEOUT)` bits wide.
- The rest is a single always_ff FSM plus the script register array.

## Test plan
- Load 2 steps {16'h0000, A5, chk} and {16'h4022, A5, chk}; responder returns A5 for both → `done` = 1, `pass` = 1, exactly 2 `snd_cmd` pulses.
- Same script, second response 5A → `pass` = 0, `fail_code` = 01, `fail_step` = 1, no third `snd_cmd`.
- `TIMEOUT` = 100; responder never asserts `resp_rdy` → `fail_code` = 10 exactly 100 cycles after `snd_cmd`, `fail_step` = 0.
- `resp_rdy` in the same cycle as timeout expiry with `resp` = A5 → step passes.
- `resp_rdy` arriving before `cmd_snt` → still consumed; script passes.
- Assert `rst` during WAIT_RESP; `start` while `busy`; `ld_en` while `busy`; `num_steps` = 0 → all outputs return to reset values; second start ignored; entry unchanged; `done` = 1 and `pass` = 1 at t+2.
